// File: rtl/dmem_arbiter_if.sv
// One requester port into the data-memory arbiter. The requester holds req and its
// access fields steady until ack. rdata is valid with ack and stays put afterwards.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wena;
  logic [1:0]        wbh;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wena, wbh, addr, wdata, input ack, rdata);
  modport slave  (input req, wena, wbh, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares single-port scdatamem between CPU (m0) and loader/debug (m1). req in IDLE -> mem access next cycle -> ack the cycle after.
// One access per 3 cycles; losers keep req high and wait for a later IDLE; round-robin or m0-fixed priority on ties.
module dmem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_wena,
  output logic [1:0]        mem_wbh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   any_req;
  logic   winner;

  // With a single requester its own index wins; on a tie the priority rule decides.
  always_comb begin
    any_req = m0.req | m1.req;
    winner  = m1.req;
    if (m0.req && m1.req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end
  end

  // The mem_* registers double as the latched request, so later changes on the
  // requester side never reach the memory during ACCESS or RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      mem_wena   <= 1'b0;
      mem_wbh    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0.ack     <= 1'b0;
      m1.ack     <= 1'b0;
      m0.rdata   <= '0;
      m1.rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state      <= S_ACCESS;
            owner      <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            mem_wena   <= winner ? m1.wena  : m0.wena;
            mem_wbh    <= winner ? m1.wbh   : m0.wbh;
            mem_addr   <= winner ? m1.addr  : m0.addr;
            mem_wdata  <= winner ? m1.wdata : m0.wdata;
          end
        end
        S_ACCESS: begin
          state    <= S_RESP;
          mem_wena <= 1'b0;
          if (!mem_wena) begin
            if (owner) m1.rdata <= mem_rdata;
            else       m0.rdata <= mem_rdata;
          end
          if (owner) m1.ack <= 1'b1;
          else       m0.ack <= 1'b1;
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          m0.ack <= 1'b0;
          m1.ack <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          m0.ack <= 1'b0;
          m1.ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each on its own memory stub,
// directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r1 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f1 ();

  logic          r_wena, f_wena, r_owner, f_owner, r_busy, f_busy;
  logic [1:0]    r_wbh, f_wbh;
  logic [AW-1:0] r_addr, f_addr;
  logic [DW-1:0] r_wdata, f_wdata, r_rdata, f_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
    .clock(clock), .reset(reset), .m0(r0), .m1(r1),
    .mem_wena(r_wena), .mem_wbh(r_wbh), .mem_addr(r_addr), .mem_wdata(r_wdata),
    .mem_rdata(r_rdata), .owner(r_owner), .busy(r_busy)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset), .m0(f0), .m1(f1),
    .mem_wena(f_wena), .mem_wbh(f_wbh), .mem_addr(f_addr), .mem_wdata(f_wdata),
    .mem_rdata(f_rdata), .owner(f_owner), .busy(f_busy)
  );

  // Word-wide memory stubs (64 words), preloaded through pl_* while reset is held.
  logic [DW-1:0] mem_r [64];
  logic [DW-1:0] mem_f [64];
  logic          pl_en  = 1'b0;
  logic [5:0]    pl_idx = '0;
  logic [DW-1:0] pl_dat = '0;

  always @(posedge clock) begin
    if (pl_en) begin
      mem_r[pl_idx] <= pl_dat;
      mem_f[pl_idx] <= pl_dat;
    end else begin
      if (r_wena) mem_r[r_addr[7:2]] <= r_wdata;
      if (f_wena) mem_f[f_addr[7:2]] <= f_wdata;
    end
  end
  assign r_rdata = mem_r[r_addr[7:2]];
  assign f_rdata = mem_f[f_addr[7:2]];

  function automatic logic [DW-1:0] pre(input int i);
    return 32'h5a00_0000 | DW'(i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ports();
    r0.req = 0; r0.wena = 0; r0.wbh = 0; r0.addr = 0; r0.wdata = 0;
    r1.req = 0; r1.wena = 0; r1.wbh = 0; r1.addr = 0; r1.wdata = 0;
    f0.req = 0; f0.wena = 0; f0.wbh = 0; f0.addr = 0; f0.wdata = 0;
    f1.req = 0; f1.wena = 0; f1.wbh = 0; f1.addr = 0; f1.wdata = 0;
  endtask

  task automatic test_reset();
    clear_ports();
    reset = 1'b0;
    r0.req = 1; r1.req = 1; f0.req = 1; f1.req = 1;
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_idx = 6'(i); pl_dat = pre(i);
      tick();
    end
    pl_en = 1'b0;
    checks++;
    if ({r0.ack, r1.ack, r0.rdata, r1.rdata, r_wena, r_wbh, r_addr, r_wdata, r_owner, r_busy} !== '0) begin
      errors++;
      $display("FAIL rst_outputs_rr: got ack=%b%b wena=%b addr=%h owner=%b busy=%b, required all 0",
               r0.ack, r1.ack, r_wena, r_addr, r_owner, r_busy);
    end
    checks++;
    if ({f0.ack, f1.ack, f0.rdata, f1.rdata, f_wena, f_wbh, f_addr, f_wdata, f_owner, f_busy} !== '0) begin
      errors++;
      $display("FAIL rst_outputs_fp: got ack=%b%b wena=%b addr=%h owner=%b busy=%b, required all 0",
               f0.ack, f1.ack, f_wena, f_addr, f_owner, f_busy);
    end
    f0.req = 0; f1.req = 0;
    reset = 1'b1;
    tick();
    checks++;
    if (r_owner !== 1'b0 || r_busy !== 1'b1 || r_wena !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_grant: got owner=%b busy=%b wena=%b, required owner=0 busy=1 wena=0",
               r_owner, r_busy, r_wena);
    end
    tick();
    checks++;
    if (r0.ack !== 1'b1 || r1.ack !== 1'b0 || r0.rdata !== pre(0)) begin
      errors++;
      $display("FAIL rst_first_ack: got ack0=%b ack1=%b rdata0=%h, required 1 0 %h",
               r0.ack, r1.ack, r0.rdata, pre(0));
    end
    r0.req = 0; r1.req = 0;
    tick();
  endtask

  task automatic test_write_read();
    r1.req = 1; r1.wena = 1; r1.wbh = 2'd0; r1.addr = 13'h010; r1.wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (r_wena !== 1'b1 || r_addr !== 13'h010 || r_wdata !== 32'hDEAD_BEEF || r_owner !== 1'b1 || r1.ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: got wena=%b addr=%h wdata=%h owner=%b ack1=%b, required 1 010 deadbeef 1 0",
               r_wena, r_addr, r_wdata, r_owner, r1.ack);
    end
    tick();
    checks++;
    if (r_wena !== 1'b0 || r1.ack !== 1'b1 || r0.ack !== 1'b0 || r_addr !== 13'h010) begin
      errors++;
      $display("FAIL wr_resp: got wena=%b ack1=%b ack0=%b addr=%h, required 0 1 0 010",
               r_wena, r1.ack, r0.ack, r_addr);
    end
    r1.req = 0;
    tick();
    checks++;
    if (mem_r[4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_commit: got mem[0x010]=%h, required deadbeef", mem_r[4]);
    end
    r0.req = 1; r0.wena = 0; r0.wbh = 2'b10; r0.addr = 13'h010;
    tick();
    checks++;
    if (r_wena !== 1'b0 || r_wbh !== 2'b10 || r_owner !== 1'b0) begin
      errors++;
      $display("FAIL rd_access: got wena=%b wbh=%b owner=%b, required 0 10 0", r_wena, r_wbh, r_owner);
    end
    tick();
    checks++;
    if (r0.ack !== 1'b1 || r0.rdata !== 32'hDEAD_BEEF || r1.rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_resp: got ack0=%b rdata0=%h rdata1=%h, required 1 deadbeef 00000000",
               r0.ack, r0.rdata, r1.rdata);
    end
    r0.req = 0; r0.wbh = 0;
    tick();
  endtask

  task automatic test_rr_contention();
    int ord[$];
    int at[$];
    reset = 1'b0; tick(); reset = 1'b1;
    r0.req = 1; r0.wena = 0; r0.addr = 13'h004;
    r1.req = 1; r1.wena = 0; r1.addr = 13'h008;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (r0.ack) begin
        ord.push_back(0); at.push_back(c);
        checks++;
        if (r0.rdata !== pre(1)) begin
          errors++;
          $display("FAIL rr_rdata0: got %h, required %h", r0.rdata, pre(1));
        end
      end
      if (r1.ack) begin
        ord.push_back(1); at.push_back(c);
        checks++;
        if (r1.rdata !== pre(2)) begin
          errors++;
          $display("FAIL rr_rdata1: got %h, required %h", r1.rdata, pre(2));
        end
      end
    end
    r0.req = 0; r1.req = 0;
    checks++;
    if (ord.size() != 4) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d acks, required 4", ord.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ord[k] != (k % 2) || at[k] != 2 + 3 * k) begin
          errors++;
          $display("FAIL rr_order[%0d]: got port %0d at cycle %0d, required port %0d at cycle %0d",
                   k, ord[k], at[k], k % 2, 2 + 3 * k);
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_fixed_prio();
    int ord[$];
    int at[$];
    f0.req = 1; f0.wena = 0; f0.addr = 13'h00C;
    f1.req = 1; f1.wena = 0; f1.addr = 13'h014;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (f0.ack) begin ord.push_back(0); at.push_back(c); end
      if (f1.ack) begin ord.push_back(1); at.push_back(c); end
      if (c == 8) f0.req = 0;
      if (c == 11) f1.req = 0;
    end
    checks++;
    if (ord.size() != 4) begin
      errors++;
      $display("FAIL fp_ack_count: got %0d acks, required 4", ord.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ord[k] != (k == 3 ? 1 : 0) || at[k] != 2 + 3 * k) begin
          errors++;
          $display("FAIL fp_order[%0d]: got port %0d at cycle %0d, required port %0d at cycle %0d",
                   k, ord[k], at[k], (k == 3 ? 1 : 0), 2 + 3 * k);
        end
      end
    end
    checks++;
    if (f1.rdata !== pre(5) || f0.rdata !== pre(3)) begin
      errors++;
      $display("FAIL fp_rdata: got rdata0=%h rdata1=%h, required %h %h", f0.rdata, f1.rdata, pre(3), pre(5));
    end
    tick();
  endtask

  task automatic test_field_change();
    r0.req = 1; r0.wena = 1; r0.wbh = 2'd0; r0.addr = 13'h020; r0.wdata = 32'h1122_3344;
    tick();
    r0.addr = 13'h040; r0.wdata = 32'h9999_9999; r0.wbh = 2'd3;
    #1;
    checks++;
    if (r_addr !== 13'h020 || r_wdata !== 32'h1122_3344 || r_wbh !== 2'd0 || r_wena !== 1'b1) begin
      errors++;
      $display("FAIL chg_access: got addr=%h wdata=%h wbh=%b wena=%b, required 020 11223344 00 1",
               r_addr, r_wdata, r_wbh, r_wena);
    end
    tick();
    checks++;
    if (r0.ack !== 1'b1 || r_addr !== 13'h020) begin
      errors++;
      $display("FAIL chg_resp: got ack0=%b addr=%h, required 1 020", r0.ack, r_addr);
    end
    r0.req = 0; r0.wena = 0; r0.wbh = 0;
    tick();
    checks++;
    if (mem_r[8] !== 32'h1122_3344 || mem_r[16] !== pre(16)) begin
      errors++;
      $display("FAIL chg_commit: got mem[020]=%h mem[040]=%h, required 11223344 %h", mem_r[8], mem_r[16], pre(16));
    end
  endtask

  task automatic test_reset_mid_access();
    bit stray;
    int got;
    stray = 0;
    got = 0;
    r1.req = 1; r1.wena = 1; r1.wbh = 0; r1.addr = 13'h030; r1.wdata = 32'hCAFE_F00D;
    tick();
    checks++;
    if (r_wena !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_wena: got %b, required 1", r_wena);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (r_wena !== 1'b0 || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_drop: got wena=%b busy=%b, required 0 0", r_wena, r_busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (r1.ack !== 1'b0) stray = 1;
    end
    checks++;
    if (stray || mem_r[12] !== pre(12)) begin
      errors++;
      $display("FAIL mid_abort: got stray_ack=%b mem[030]=%h, required 0 %h", stray, mem_r[12], pre(12));
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (r1.ack === 1'b1) begin
        got = k;
        break;
      end
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL mid_reissue_latency: got ack after %0d cycles (0 = none in 10), required 2", got);
    end
    r1.req = 0; r1.wena = 0;
    tick();
    checks++;
    if (mem_r[12] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mid_reissue_commit: got mem[030]=%h, required cafef00d", mem_r[12]);
    end
  endtask

  // Transaction-level model: a decision slot opens whenever the arbiter is free;
  // a granted access hits memory one cycle later and is acknowledged two cycles later.
  task automatic test_random();
    logic [DW-1:0] mm [64];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] pend_rd [2];
    bit            p_req [2];
    bit            p_wena [2];
    logic [1:0]    p_wbh [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    int            ack_at [2];
    int            next_dec, wena_at, w;
    bit            last, e_wena;
    logic [1:0]    e_wbh;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            obs_ack [2];
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 64; i++) mm[i] = mem_r[i];
    for (int p = 0; p < 2; p++) begin
      exp_rd[p] = '0; pend_rd[p] = '0; p_req[p] = 0; ack_at[p] = -1;
      p_wena[p] = 0; p_wbh[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
    end
    next_dec = 0; wena_at = -1; last = 1;
    e_wena = 0; e_wbh = 0; e_addr = 0; e_wdata = 0;
    for (int c = 0; c < 600; c++) begin
      obs_ack[0] = r0.ack;
      obs_ack[1] = r1.ack;
      for (int p = 0; p < 2; p++) begin
        if (ack_at[p] == c) exp_rd[p] = pend_rd[p];
        checks++;
        if (obs_ack[p] !== (ack_at[p] == c)) begin
          errors++;
          $display("FAIL rnd_ack%0d @%0d: got %b, required %b", p, c, obs_ack[p], (ack_at[p] == c));
        end
      end
      checks++;
      if (r0.rdata !== exp_rd[0] || r1.rdata !== exp_rd[1]) begin
        errors++;
        $display("FAIL rnd_rdata @%0d: got %h %h, required %h %h", c, r0.rdata, r1.rdata, exp_rd[0], exp_rd[1]);
      end
      checks++;
      if (c == wena_at) begin
        if (r_wena !== e_wena || r_addr !== e_addr || r_wbh !== e_wbh || (e_wena && r_wdata !== e_wdata)) begin
          errors++;
          $display("FAIL rnd_mem @%0d: got wena=%b addr=%h wbh=%b wdata=%h, required %b %h %b %h",
                   c, r_wena, r_addr, r_wbh, r_wdata, e_wena, e_addr, e_wbh, e_wdata);
        end
      end else if (r_wena !== 1'b0) begin
        errors++;
        $display("FAIL rnd_wena_idle @%0d: got %b, required 0", c, r_wena);
      end
      for (int p = 0; p < 2; p++) begin
        if (obs_ack[p]) p_req[p] = 0;
        if (!p_req[p] && $urandom_range(0, 2) == 0) begin
          p_req[p]   = 1;
          p_wena[p]  = $urandom_range(0, 1) == 1;
          p_wbh[p]   = 2'($urandom_range(0, 3));
          p_addr[p]  = {5'b0, 6'($urandom_range(0, 63)), 2'b00};
          p_wdata[p] = $urandom;
        end
      end
      r0.req = p_req[0]; r0.wena = p_wena[0]; r0.wbh = p_wbh[0]; r0.addr = p_addr[0]; r0.wdata = p_wdata[0];
      r1.req = p_req[1]; r1.wena = p_wena[1]; r1.wbh = p_wbh[1]; r1.addr = p_addr[1]; r1.wdata = p_wdata[1];
      if (c == next_dec) begin
        if (p_req[0] || p_req[1]) begin
          w = (p_req[0] && p_req[1]) ? int'(!last) : int'(p_req[1]);
          last = (w == 1);
          wena_at = c + 1;
          e_wena = p_wena[w]; e_wbh = p_wbh[w]; e_addr = p_addr[w]; e_wdata = p_wdata[w];
          if (e_wena) mm[e_addr[7:2]] = e_wdata;
          else        pend_rd[w] = mm[e_addr[7:2]];
          ack_at[w] = c + 2;
          next_dec = c + 3;
        end else begin
          next_dec = c + 1;
        end
      end
      tick();
    end
    clear_ports();
    tick(); tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_rr_contention();
    test_fixed_prio();
    test_field_change();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
